// File: rtl/sa2_operand_loader.sv
// Operand loader for the 2x2 systolic convolution array: captures a 25-byte
// frame (4x4 tile, then 3x3 filter) and holds the array enabled until done.
module sa2_operand_loader #(
  parameter int TIMEOUT = 64,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  input  logic              done_sa2,
  output logic              active_sa2,
  output logic [DATA_W-1:0] a11,
  output logic [DATA_W-1:0] a12,
  output logic [DATA_W-1:0] a13,
  output logic [DATA_W-1:0] a14,
  output logic [DATA_W-1:0] a21,
  output logic [DATA_W-1:0] a22,
  output logic [DATA_W-1:0] a23,
  output logic [DATA_W-1:0] a24,
  output logic [DATA_W-1:0] a31,
  output logic [DATA_W-1:0] a32,
  output logic [DATA_W-1:0] a33,
  output logic [DATA_W-1:0] a34,
  output logic [DATA_W-1:0] a41,
  output logic [DATA_W-1:0] a42,
  output logic [DATA_W-1:0] a43,
  output logic [DATA_W-1:0] a44,
  output logic [DATA_W-1:0] b11,
  output logic [DATA_W-1:0] b12,
  output logic [DATA_W-1:0] b13,
  output logic [DATA_W-1:0] b21,
  output logic [DATA_W-1:0] b22,
  output logic [DATA_W-1:0] b23,
  output logic [DATA_W-1:0] b31,
  output logic [DATA_W-1:0] b32,
  output logic [DATA_W-1:0] b33,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [4:0] LAST_BYTE = 5'd24;
  localparam logic [7:0] WD_LAST   = 8'(TIMEOUT - 1);

  state_t            state;
  logic [4:0]        cnt;
  logic [7:0]        wd;
  logic [DATA_W-1:0] opnd [25];

  assign in_ready = (state != RUN);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wd          <= '0;
      active_sa2  <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 25; i++) opnd[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd[0]     <= in_data;
            cnt         <= 5'd1;
            timeout_err <= 1'b0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          // flush wins over a same-cycle byte; stale operands are left in place
          if (flush) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (in_valid) begin
            opnd[cnt] <= in_data;
            if (cnt == LAST_BYTE) begin
              cnt        <= '0;
              wd         <= '0;
              active_sa2 <= 1'b1;
              state      <= RUN;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        RUN: begin
          // done takes precedence over a watchdog expiry in the same cycle
          if (done_sa2) begin
            active_sa2 <= 1'b0;
            wd         <= '0;
            state      <= IDLE;
          end else if (wd == WD_LAST) begin
            active_sa2  <= 1'b0;
            wd          <= '0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign a11 = opnd[0];
  assign a12 = opnd[1];
  assign a13 = opnd[2];
  assign a14 = opnd[3];
  assign a21 = opnd[4];
  assign a22 = opnd[5];
  assign a23 = opnd[6];
  assign a24 = opnd[7];
  assign a31 = opnd[8];
  assign a32 = opnd[9];
  assign a33 = opnd[10];
  assign a34 = opnd[11];
  assign a41 = opnd[12];
  assign a42 = opnd[13];
  assign a43 = opnd[14];
  assign a44 = opnd[15];
  assign b11 = opnd[16];
  assign b12 = opnd[17];
  assign b13 = opnd[18];
  assign b21 = opnd[19];
  assign b22 = opnd[20];
  assign b23 = opnd[21];
  assign b31 = opnd[22];
  assign b32 = opnd[23];
  assign b33 = opnd[24];

endmodule
